// File: rtl/shift_reg_ctrl.sv
// Sequencer and round-robin two-way arbiter in front of a WIDTH-bit SIPO shift register.
// Optional readback compare is enabled by defining SHIFT_REG_CTRL_CHECK_EN.
module shift_reg_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             sr_d,
  output logic             sr_pr,
  output logic             sr_clr,
  input  logic [WIDTH-1:0] sr_q,
  output logic             done,
  output logic             done_id,
  output logic             check_ok
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] word, word_nxt;
  logic             id, id_nxt;
  logic             last, last_nxt;
  logic             winner;

  // Contention goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    winner = req[1];
    if (req == 2'b11) winner = ~last;
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    word_nxt  = word;
    id_nxt    = id;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          id_nxt    = winner;
          last_nxt  = winner;
          word_nxt  = winner ? data1 : data0;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        cnt_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = CHECK;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CHECK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // NOTE: reset is synchronous to clk; clr=0 at any edge aborts back to IDLE and re-arms last=1.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= IDLE;
      cnt   <= '0;
      word  <= '0;
      id    <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      word  <= word_nxt;
      id    <= id_nxt;
      last  <= last_nxt;
    end
  end

  // Handshake outputs depend on registered state only.
  assign gnt     = (state == CLEAR) ? (id ? 2'b10 : 2'b01) : 2'b00;
  assign busy    = (state != IDLE);
  assign done    = (state == CHECK);
  assign done_id = done & id;

  // The register is held clear while the controller itself is in reset.
  assign sr_pr  = 1'b1;
  assign sr_clr = clr & (state != CLEAR);
  assign sr_d   = (state == SHIFT) ? word[CNT_LAST - cnt] : 1'b0;

`ifdef SHIFT_REG_CTRL_CHECK_EN
  assign check_ok = done & (sr_q == word);
`else
  logic unused_sr_q;
  assign unused_sr_q = ^sr_q;
  assign check_ok    = done;
`endif

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Self-checking bench for shift_reg_ctrl: vector table, corner-case sequences and a
// randomized run against a phase-based transaction model and a behavioural shift register.
module tb_shift_reg_ctrl;
  localparam int W = 4;

`ifdef SHIFT_REG_CTRL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clr;
  logic [1:0]   req;
  logic [W-1:0] data0, data1;
  logic [1:0]   gnt;
  logic         busy, sr_d, sr_pr, sr_clr;
  logic [W-1:0] sr_q;
  logic         done, done_id, check_ok;

  always #10 clk = ~clk;

  shift_reg_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .clr      (clr),
    .req      (req),
    .data0    (data0),
    .data1    (data1),
    .gnt      (gnt),
    .busy     (busy),
    .sr_d     (sr_d),
    .sr_pr    (sr_pr),
    .sr_clr   (sr_clr),
    .sr_q     (sr_q),
    .done     (done),
    .done_id  (done_id),
    .check_ok (check_ok)
  );

  // Behavioural shift register; stuck_mask forces selected flops to 0.
  logic [W-1:0] q_reg;
  logic [W-1:0] stuck_mask;
  assign sr_q = q_reg & ~stuck_mask;
  always @(posedge clk) begin
    if (!sr_clr) q_reg <= '0;
    else         q_reg <= {sr_q[W-2:0], sr_d};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_gnt(input string name, output int at, output logic [1:0] g);
    at = -1;
    g  = 2'b00;
    for (int i = 0; i < 30 && at < 0; i++) begin
      step();
      if (gnt !== 2'b00) begin
        at = cyc;
        g  = gnt;
      end
    end
    if (at < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no gnt within 30 cycles", name);
    end
  endtask

  // Runs one complete operation starting at a negedge with the DUT idle.
  task automatic run_txn(input string tag, input logic [1:0] r, input logic [W-1:0] d0,
                         input logic [W-1:0] d1, input logic eid, input logic [W-1:0] ew,
                         input logic eok);
    req = r; data0 = d0; data1 = d1;
    step();
    check($sformatf("%s gnt", tag), gnt, eid ? 2'b10 : 2'b01);
    check($sformatf("%s busy", tag), busy, 1'b1);
    check($sformatf("%s sr_clr", tag), sr_clr, 1'b0);
    req = 2'b00; data0 = W'($urandom); data1 = W'($urandom);
    for (int p = 2; p <= W + 1; p++) begin
      step();
      check($sformatf("%s sr_d p%0d", tag, p), sr_d, ew[W + 1 - p]);
      if (p == 2) check($sformatf("%s gnt pulse", tag), gnt, 2'b00);
    end
    step();
    check($sformatf("%s done", tag), done, 1'b1);
    check($sformatf("%s done_id", tag), done_id, eid);
    check($sformatf("%s check_ok", tag), check_ok, eok);
    step();
    check($sformatf("%s done end", tag), done, 1'b0);
    check($sformatf("%s busy end", tag), busy, 1'b0);
  endtask

  task automatic do_reset(input int edges);
    clr = 1'b0;
    req = 2'b00;
    repeat (edges) step();
    clr = 1'b1;
  endtask

  typedef struct {
    logic [1:0]   req;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         exp_id;
    logic [W-1:0] exp_word;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t0, t1, gap_at;
    logic [1:0] g;
    int         gc[3];
    logic [1:0] gv[3];
    bit         done_seen;
    int         m_p;
    logic       m_last, m_id, w;
    logic [W-1:0] m_word;
    logic [1:0] pend;
    logic [8:0] exp_v, act_v;

    // Rows run in order; the last two rows contend and depend on the preceding winners.
    vecs[0] = '{2'b01, 4'hB, 4'h0, 1'b0, 4'hB};
    vecs[1] = '{2'b10, 4'h7, 4'h6, 1'b1, 4'h6};
    vecs[2] = '{2'b01, 4'h0, 4'hF, 1'b0, 4'h0};
    vecs[3] = '{2'b10, 4'h8, 4'h1, 1'b1, 4'h1};
    vecs[4] = '{2'b01, 4'hF, 4'h0, 1'b0, 4'hF};
    vecs[5] = '{2'b11, 4'h5, 4'hA, 1'b1, 4'hA};
    vecs[6] = '{2'b11, 4'h9, 4'h6, 1'b0, 4'h9};

    stuck_mask = '0;
    data0 = '0; data1 = '0;

    // Reset with both requests asserted.
    clr = 1'b0; req = 2'b11;
    step(); step();
    check("rst gnt", gnt, 2'b00);
    check("rst busy", busy, 1'b0);
    check("rst sr_d", sr_d, 1'b0);
    check("rst sr_pr", sr_pr, 1'b1);
    check("rst sr_clr", sr_clr, 1'b0);
    check("rst done", done, 1'b0);
    check("rst done_id", done_id, 1'b0);
    check("rst check_ok", check_ok, 1'b0);
    req = 2'b00; clr = 1'b1;
    step();
    check("idle sr_clr", sr_clr, 1'b1);
    check("idle busy", busy, 1'b0);

    // Table of single and contending transactions.
    for (int i = 0; i < 7; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].req, vecs[i].d0, vecs[i].d1,
              vecs[i].exp_id, vecs[i].exp_word, 1'b1);

    // Sustained contention from reset: grants alternate 0,1,0 every W+3 cycles.
    do_reset(2);
    req = 2'b11; data0 = 4'h3; data1 = 4'hC;
    for (int k = 0; k < 3; k++) begin
      wait_gnt($sformatf("cont%0d", k), gc[k], gv[k]);
      check($sformatf("cont%0d gnt", k), gv[k], (k == 1) ? 2'b10 : 2'b01);
      repeat (W + 1) step();
      check($sformatf("cont%0d done", k), done, 1'b1);
      check($sformatf("cont%0d done_id", k), done_id, (k == 1) ? 1'b1 : 1'b0);
      check($sformatf("cont%0d check_ok", k), check_ok, 1'b1);
      if (k > 0) check($sformatf("cont%0d gap", k), gc[k] - gc[k-1], W + 3);
    end
    req = 2'b00;
    step();

    // Stuck-at-0 q[2]: readback mismatch is reported only when the compare is built in.
    stuck_mask = 4'b0100;
    run_txn("stuck", 2'b10, 4'h0, 4'hF, 1'b1, 4'hF, CHK ? 1'b0 : 1'b1);
    stuck_mask = '0;

    // Abort during SHIFT: reset for one edge after E3, no done afterwards.
    req = 2'b01; data0 = 4'hD;
    step();
    check("abort gnt", gnt, 2'b01);
    req = 2'b00;
    step(); step();
    clr = 1'b0;
    #1;
    check("abort sr_clr in rst", sr_clr, 1'b0);
    step();
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort sr_clr held", sr_clr, 1'b0);
    clr = 1'b1;
    done_seen = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      step();
      if (done === 1'b1) done_seen = 1'b1;
    end
    check("abort no done", done_seen, 1'b0);
    run_txn("post_abort", 2'b10, 4'h0, 4'h5, 1'b1, 4'h5, 1'b1);

    // After a reset, last=1 again, so contention goes to requester 0.
    do_reset(1);
    run_txn("rst_last", 2'b11, 4'h6, 4'h9, 1'b0, 4'h6, 1'b1);

    // Late request raised during SHIFT waits for the IDLE cycle after CHECK.
    req = 2'b01; data0 = 4'hA;
    step();
    t0 = cyc;
    check("late first gnt", gnt, 2'b01);
    req = 2'b00;
    step(); step();
    req = 2'b10; data1 = 4'h6;
    wait_gnt("late", t1, g);
    req = 2'b00;
    check("late gnt", g, 2'b10);
    gap_at = t1 - t0;
    check("late gap", gap_at, W + 3);
    repeat (W + 1) step();
    check("late done_id", done_id, 1'b1);
    check("late check_ok", check_ok, 1'b1);
    step();

    // Randomized run against a transaction-phase model (phase 0 = idle, 1 = grant, W+2 = done).
    do_reset(1);
    m_p = 0; m_last = 1'b1; m_id = 1'b0; m_word = '0;
    pend = 2'b00;
    for (int t = 0; t < 600; t++) begin
      clr = ($urandom_range(0, 49) != 0);
      for (int i = 0; i < 2; i++)
        req[i] = pend[i] ? 1'b1 : ($urandom_range(0, 3) == 0);
      data0 = W'($urandom);
      data1 = W'($urandom);
      step();
      if (!clr) begin
        m_p = 0;
        m_last = 1'b1;
      end else if (m_p == 0) begin
        if (req != 2'b00) begin
          if (req[0] && req[1]) w = !m_last;
          else                  w = req[1];
          m_id = w; m_last = w;
          m_word = w ? data1 : data0;
          m_p = 1;
        end
      end else if (m_p == W + 2) begin
        m_p = 0;
      end else begin
        m_p++;
      end
      exp_v[8:7] = (m_p == 1) ? (m_id ? 2'b10 : 2'b01) : 2'b00;
      exp_v[6]   = (m_p != 0);
      exp_v[5]   = (m_p >= 2 && m_p <= W + 1) ? m_word[W + 1 - m_p] : 1'b0;
      exp_v[4]   = clr && (m_p != 1);
      exp_v[3]   = 1'b1;
      exp_v[2]   = (m_p == W + 2);
      exp_v[1]   = (m_p == W + 2) ? m_id : 1'b0;
      exp_v[0]   = (m_p == W + 2);
      act_v = {gnt, busy, sr_d, sr_clr, sr_pr, done, done_id, check_ok};
      check($sformatf("rand t%0d {gnt,busy,sr_d,sr_clr,sr_pr,done,done_id,check_ok}", t),
            act_v, exp_v);
      pend = req & ~gnt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
